// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: parser states, abort codes and default frame marker shared by the frame parser.
package uart_frame_pkg;
  typedef enum logic [2:0] {ST_HUNT, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHKSUM, ST_HOLD} state_e;
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_PARITY   = 3'd1;
  localparam logic [2:0] ERR_FRAMING  = 3'd2;
  localparam logic [2:0] ERR_LEN      = 3'd3;
  localparam logic [2:0] ERR_CHECKSUM = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
  function automatic logic in_frame(state_e s);
    return s inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHKSUM};
  endfunction
endpackage

// File: rtl/uart_frame_payload_buf.sv
// uart_frame_payload_buf: single-write, registered-read payload store; contents survive reset.
module uart_frame_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_d, rd_data_q;
  always_comb rd_data_d = mem[rd_addr];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= rst ? '0 : rd_data_d;
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: assembles SYNC/CMD/LEN/PAYLOAD/CHK frames from the UART byte stream and presents them via valid/ack.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int          MAX_PAYLOAD    = 16,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          ADDR_WIDTH     = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iDE,
  input  logic [7:0]            iDATA,
  input  logic                  iRETRY,
  input  logic                  iPARITY_ERROR,
  input  logic                  iCMD_ACK,
  input  logic [ADDR_WIDTH-1:0] iRD_ADDR,
  output logic                  oCMD_VALID,
  output logic [7:0]            oCMD,
  output logic [7:0]            oLEN,
  output logic [7:0]            oRD_DATA,
  output logic                  oFRAME_ERROR,
  output logic [2:0]            oERR_CODE,
  output logic                  oOVERRUN,
  output logic [7:0]            oERR_CNT
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
  state_e state_q, state_d;
  logic [7:0] cmd_q, cmd_d, len_q, len_d, chk_q, chk_d, cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0] code_q, code_d, abort_code;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic good, par, frm, live, timeout, abort, we;
  assign par = iDE & iPARITY_ERROR;
  assign frm = ~iDE & iRETRY;
  assign good = iDE & ~iPARITY_ERROR;
  assign live = in_frame(state_q);
  // the counter is compared before its increment, so an iDE on the terminal cycle still wins
  assign timeout = live & ~iDE & (tmo_q == TMO_LAST);
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    len_d = len_q;
    idx_d = idx_q;
    chk_d = chk_q;
    tmo_d = (live & ~iDE) ? tmo_q + 1'b1 : '0;
    valid_d = valid_q;
    ovr_d = 1'b0;
    we = 1'b0;
    abort = live & (par | frm | timeout);
    abort_code = par ? ERR_PARITY : frm ? ERR_FRAMING : timeout ? ERR_TIMEOUT : ERR_NONE;
    case (state_q)
      ST_HUNT: if (good && iDATA == SYNC_BYTE) begin
        state_d = ST_CMD;
        chk_d = '0;
      end
      ST_CMD: if (good) begin
        cmd_d = iDATA;
        chk_d = chk_q ^ iDATA;
        state_d = ST_LEN;
      end
      ST_LEN: if (good) begin
        len_d = iDATA;
        chk_d = chk_q ^ iDATA;
        if (int'(iDATA) > MAX_PAYLOAD) begin
          abort = 1'b1;
          abort_code = ERR_LEN;
        end else if (iDATA == 8'd0) begin
          state_d = ST_CHKSUM;
        end else begin
          idx_d = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (good) begin
        we = 1'b1;
        chk_d = chk_q ^ iDATA;
        idx_d = idx_q + 1'b1;
        state_d = (8'(idx_q) == len_q - 8'd1) ? ST_CHKSUM : ST_PAYLOAD;
      end
      ST_CHKSUM: if (good) begin
        if (iDATA == chk_q) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end else begin
          abort = 1'b1;
          abort_code = ERR_CHECKSUM;
        end
      end
      ST_HOLD: begin
        ovr_d = iDE;
        if (iCMD_ACK) begin
          valid_d = 1'b0;
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
    if (abort) state_d = ST_HUNT;
    ferr_d = abort;
    code_d = abort ? abort_code : code_q;
    cnt_d = ((abort | ovr_d) && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HUNT;
      cmd_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      chk_q <= '0;
      tmo_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      code_q <= ERR_NONE;
      ovr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      len_q <= len_d;
      idx_q <= idx_d;
      chk_q <= chk_d;
      tmo_q <= tmo_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      code_q <= code_d;
      ovr_q <= ovr_d;
      cnt_q <= cnt_d;
    end
  end
  uart_frame_payload_buf #(.DEPTH(MAX_PAYLOAD), .AW(ADDR_WIDTH)) u_buf (
    .clk(CLK),
    .rst(RST),
    .we(we),
    .wr_addr(idx_q),
    .wr_data(iDATA),
    .rd_addr(iRD_ADDR),
    .rd_data(oRD_DATA)
  );
  assign oCMD_VALID = valid_q;
  assign oCMD = cmd_q;
  assign oLEN = len_q;
  assign oFRAME_ERROR = ferr_q;
  assign oERR_CODE = code_q;
  assign oOVERRUN = ovr_q;
  assign oERR_CNT = cnt_q;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser: scoreboard bench; expected frame/abort/overrun events are queued as bytes are driven.
module tb_uart_rx_frame_parser;
  localparam int MAXP = 16;
  localparam int AW = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  logic CLK = 1'b0, RST = 1'b1, iDE = 1'b0, iRETRY = 1'b0, iPARITY_ERROR = 1'b0, iCMD_ACK = 1'b0;
  logic [7:0] iDATA = 8'h00;
  logic [AW-1:0] iRD_ADDR = '0;
  logic oCMD_VALID, oFRAME_ERROR, oOVERRUN;
  logic [7:0] oCMD, oLEN, oRD_DATA, oERR_CNT;
  logic [2:0] oERR_CODE;
  typedef struct {int kind; logic [7:0] a; logic [7:0] b;} ev_t;
  ev_t exp_q[$];
  ev_t ev;
  int n_cmp = 0, n_bad = 0, exp_cnt = 0;
  logic [7:0] pl [MAXP];
  logic [7:0] mdl_buf [MAXP];
  logic prev_valid = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx_frame_parser #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .iDE(iDE), .iDATA(iDATA), .iRETRY(iRETRY),
    .iPARITY_ERROR(iPARITY_ERROR), .iCMD_ACK(iCMD_ACK), .iRD_ADDR(iRD_ADDR),
    .oCMD_VALID(oCMD_VALID), .oCMD(oCMD), .oLEN(oLEN), .oRD_DATA(oRD_DATA),
    .oFRAME_ERROR(oFRAME_ERROR), .oERR_CODE(oERR_CODE), .oOVERRUN(oOVERRUN), .oERR_CNT(oERR_CNT)
  );

  function automatic void push_ev(input int k, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
  endfunction

  // kind 1 = frame presented, 2 = abort, 3 = overrun
  always @(negedge CLK) begin
    if (oCMD_VALID === 1'b1 && !prev_valid) begin
      n_cmp++;
      if (exp_q.size() > 0) ev = exp_q.pop_front(); else ev.kind = 0;
      if (ev.kind != 1 || ev.a !== oCMD || ev.b !== oLEN) begin
        n_bad++;
        $display("FAIL cmd_valid_event: got cmd=%h len=%h, expected kind=1 cmd=%h len=%h (queued kind %0d)", oCMD, oLEN, ev.a, ev.b, ev.kind);
      end
    end
    if (oFRAME_ERROR === 1'b1) begin
      n_cmp++;
      if (exp_q.size() > 0) ev = exp_q.pop_front(); else ev.kind = 0;
      if (ev.kind != 2 || ev.a !== {5'd0, oERR_CODE}) begin
        n_bad++;
        $display("FAIL frame_error_event: got code=%0d, expected kind=2 code=%0d (queued kind %0d)", oERR_CODE, ev.a, ev.kind);
      end
    end
    if (oOVERRUN === 1'b1) begin
      n_cmp++;
      if (exp_q.size() > 0) ev = exp_q.pop_front(); else ev.kind = 0;
      if (ev.kind != 3) begin
        n_bad++;
        $display("FAIL overrun_event: got overrun pulse, expected queued kind 3, got kind %0d", ev.kind);
      end
    end
    prev_valid <= (oCMD_VALID === 1'b1);
  end

  task automatic drive_raw(input logic de, input logic par, input logic rt, input logic [7:0] d);
    iDE = de;
    iPARITY_ERROR = par;
    iRETRY = rt;
    iDATA = d;
    @(posedge CLK); #1;
    iDE = 1'b0;
    iPARITY_ERROR = 1'b0;
    iRETRY = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    drive_raw(1'b1, 1'b0, 1'b0, b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len, input bit bad);
    logic [7:0] c;
    c = cmd ^ 8'(len);
    drive_byte(SYNC);
    drive_byte(cmd);
    drive_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      drive_byte(pl[i]);
      mdl_buf[i] = pl[i];
      c ^= pl[i];
    end
    n_cmp++;
    if (oCMD_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL valid_early: oCMD_VALID=%b before CHK, required 0", oCMD_VALID);
    end
    if (bad) begin
      push_ev(2, 8'd4, 8'd0);
      exp_cnt++;
      drive_byte(c ^ 8'h01);
    end else begin
      push_ev(1, cmd, 8'(len));
      drive_byte(c);
    end
  endtask

  task automatic read_check(input int n);
    for (int i = 0; i < n; i++) begin
      iRD_ADDR = 4'(i);
      @(posedge CLK); #1;
      n_cmp++;
      if (oRD_DATA !== mdl_buf[i]) begin
        n_bad++;
        $display("FAIL rd_data[%0d]: got %h, required %h", i, oRD_DATA, mdl_buf[i]);
      end
    end
  endtask

  task automatic do_ack();
    iCMD_ACK = 1'b1;
    @(posedge CLK); #1;
    iCMD_ACK = 1'b0;
    n_cmp++;
    if (oCMD_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_clears_valid: oCMD_VALID=%b, required 0", oCMD_VALID);
    end
  endtask

  task automatic check_presented(input logic [7:0] cmd, input logic [7:0] len);
    n_cmp++;
    if (oCMD_VALID !== 1'b1 || oCMD !== cmd || oLEN !== len) begin
      n_bad++;
      $display("FAIL presented: valid=%b cmd=%h len=%h, required valid=1 cmd=%h len=%h", oCMD_VALID, oCMD, oLEN, cmd, len);
    end
  endtask

  task automatic check_err(input logic [2:0] code);
    n_cmp++;
    if (oERR_CODE !== code || oERR_CNT !== 8'(exp_cnt)) begin
      n_bad++;
      $display("FAIL err_state: code=%0d cnt=%0d, required code=%0d cnt=%0d", oERR_CODE, oERR_CNT, code, exp_cnt);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({oCMD_VALID, oCMD, oLEN, oRD_DATA, oFRAME_ERROR, oERR_CODE, oOVERRUN, oERR_CNT} !== '0) begin
      n_bad++;
      $display("FAIL %s: valid=%b cmd=%h len=%h rd=%h ferr=%b code=%0d ovr=%b cnt=%0d, required all 0",
               tag, oCMD_VALID, oCMD, oLEN, oRD_DATA, oFRAME_ERROR, oERR_CODE, oOVERRUN, oERR_CNT);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(2);
    check_all_zero("reset_outputs");
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(8'h10, 3, 1'b0);
    check_presented(8'h10, 8'd3);
    read_check(3);
    check_presented(8'h10, 8'd3);
    do_ack();
  endtask

  task automatic test_len_zero();
    send_frame(8'h20, 0, 1'b0);
    check_presented(8'h20, 8'd0);
    do_ack();
    send_frame(8'h20, 0, 1'b1);
    check_err(3'd4);
  endtask

  task automatic test_len_too_big();
    drive_byte(SYNC);
    drive_byte(8'h30);
    push_ev(2, 8'd3, 8'd0);
    exp_cnt++;
    drive_byte(8'h11);
    check_err(3'd3);
    pl[0] = 8'hAA; pl[1] = 8'h55;
    send_frame(8'h40, 2, 1'b0);
    check_presented(8'h40, 8'd2);
    read_check(2);
    do_ack();
  endtask

  task automatic test_line_errors();
    drive_byte(SYNC);
    drive_byte(8'h10);
    drive_byte(8'h03);
    drive_byte(8'h11);
    mdl_buf[0] = 8'h11;
    push_ev(2, 8'd1, 8'd0);
    exp_cnt++;
    drive_raw(1'b1, 1'b1, 1'b0, 8'h22);
    check_err(3'd1);
    drive_byte(SYNC);
    drive_byte(8'h10);
    push_ev(2, 8'd2, 8'd0);
    exp_cnt++;
    drive_raw(1'b0, 1'b0, 1'b1, 8'h00);
    check_err(3'd2);
    drive_byte(8'h00);
    drive_byte(8'hFF);
    drive_raw(1'b1, 1'b1, 1'b0, SYNC);
    drive_raw(1'b0, 1'b0, 1'b1, 8'h00);
    idle(2);
    check_err(3'd2);
  endtask

  task automatic test_timeout();
    drive_byte(SYNC);
    idle(14);
    n_cmp++;
    if (oFRAME_ERROR !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: oFRAME_ERROR=%b, required 0", oFRAME_ERROR);
    end
    push_ev(2, 8'd5, 8'd0);
    exp_cnt++;
    idle(1);
    n_cmp++;
    if (oFRAME_ERROR !== 1'b1 || oERR_CODE !== 3'd5) begin
      n_bad++;
      $display("FAIL timeout_abort: ferr=%b code=%0d, required ferr=1 code=5", oFRAME_ERROR, oERR_CODE);
    end
    drive_byte(SYNC);
    idle(14);
    drive_byte(8'h42);
    n_cmp++;
    if (oFRAME_ERROR !== 1'b0 || oERR_CNT !== 8'(exp_cnt)) begin
      n_bad++;
      $display("FAIL timeout_rescued: ferr=%b cnt=%0d, required ferr=0 cnt=%0d", oFRAME_ERROR, oERR_CNT, exp_cnt);
    end
    drive_byte(8'h00);
    push_ev(1, 8'h42, 8'h00);
    drive_byte(8'h42);
    check_presented(8'h42, 8'd0);
    do_ack();
  endtask

  task automatic test_overrun();
    pl[0] = 8'hC3; pl[1] = 8'h3C;
    send_frame(8'h55, 2, 1'b0);
    push_ev(3, 8'd0, 8'd0);
    drive_byte(8'h99);
    push_ev(3, 8'd0, 8'd0);
    drive_byte(8'h77);
    exp_cnt += 2;
    check_presented(8'h55, 8'd2);
    read_check(2);
    check_err(3'd5);
    push_ev(3, 8'd0, 8'd0);
    exp_cnt++;
    iDE = 1'b1;
    iDATA = SYNC;
    iCMD_ACK = 1'b1;
    @(posedge CLK); #1;
    iDE = 1'b0;
    iCMD_ACK = 1'b0;
    n_cmp++;
    if (oCMD_VALID !== 1'b0 || oERR_CNT !== 8'(exp_cnt)) begin
      n_bad++;
      $display("FAIL ack_with_byte: valid=%b cnt=%0d, required valid=0 cnt=%0d", oCMD_VALID, oERR_CNT, exp_cnt);
    end
    idle(1);
    pl[0] = 8'h5A;
    send_frame(8'h66, 1, 1'b0);
    check_presented(8'h66, 8'd1);
    read_check(1);
    do_ack();
  endtask

  task automatic test_reset_mid();
    drive_byte(SYNC);
    drive_byte(8'h10);
    drive_byte(8'h03);
    drive_byte(8'h11);
    mdl_buf[0] = 8'h11;
    RST = 1'b1;
    idle(1);
    check_all_zero("reset_mid_payload");
    RST = 1'b0;
    exp_cnt = 0;
    idle(1);
    pl[0] = 8'h01;
    send_frame(8'h70, 1, 1'b0);
    check_presented(8'h70, 8'd1);
    check_err(3'd0);
    do_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_len_too_big();
    test_line_errors();
    test_timeout();
    test_overrun();
    test_reset_mid();
    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d events still queued, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
